// File: rtl/fetch_decode.sv
// fetch_decode: byte-serial Y86-64 fetch and decode with a valid/ready output toward the register file.
module fetch_decode #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter logic [3:0]  RSP_ID   = 4'hE
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        pc_load,
    input  logic [63:0] pc_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [1:0]  stat
);
    typedef enum logic [1:0] {FETCH, OUT, STOP} state_t;
    state_t r_state, w_next;
    logic [63:0] r_pc, r_valC, r_valP;
    logic [3:0]  r_cnt, r_len, r_icode, r_ifun, r_rA, r_rB;
    logic [1:0]  r_stat;
    logic        r_go;
    logic        w_load, w_acc, w_last, w_bad, w_out, w_xfer;
    logic [3:0]  w_len;

    function automatic logic [3:0] ilen(input logic [3:0] ic);
        return (ic inside {4'h0, 4'h1, 4'h9}) ? 4'd1 :
               (ic inside {4'h2, 4'h6, 4'hA, 4'hB}) ? 4'd2 :
               (ic inside {4'h7, 4'h8}) ? 4'd9 :
               (ic inside {4'h3, 4'h4, 4'h5}) ? 4'd10 : 4'd0;
    endfunction

    // r_go idles the request for one cycle after reset or a redirect
    assign w_load   = pc_load && r_state != STOP;
    assign mem_req  = r_state == FETCH && r_go;
    assign mem_addr = r_pc + {60'd0, r_cnt};
    assign w_acc    = mem_req && mem_ack && !w_load;
    assign w_len    = r_cnt == 4'd0 ? ilen(mem_rdata[7:4]) : r_len;
    assign w_bad    = w_acc && w_len == 4'd0;
    assign w_last   = w_acc && r_cnt == w_len - 4'd1;
    assign w_out    = r_state == OUT;
    assign w_xfer   = w_out && out_ready && !w_load;

    always_ff @(posedge clock) begin
        if (reset) r_state <= FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_load)                           w_next = FETCH;
        else if (r_state == FETCH && w_bad)   w_next = STOP;
        else if (r_state == FETCH && w_last)  w_next = OUT;
        else if (w_xfer)                      w_next = r_icode == 4'h0 ? STOP : FETCH;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= RESET_PC;
            r_cnt   <= 4'd0;
            r_len   <= 4'd0;
            r_go    <= 1'b0;
            r_icode <= 4'h0;
            r_ifun  <= 4'h0;
            r_rA    <= 4'hF;
            r_rB    <= 4'hF;
            r_valC  <= 64'd0;
            r_valP  <= 64'd0;
            r_stat  <= 2'd0;
        end else if (w_load) begin
            r_pc  <= pc_in;
            r_cnt <= 4'd0;
            r_go  <= 1'b0;
        end else begin
            r_go <= 1'b1;
            if (w_acc) begin
                r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
                if (r_cnt == 4'd0) begin
                    {r_icode, r_ifun} <= mem_rdata;
                    r_len  <= w_len;
                    r_rA   <= 4'hF;
                    r_rB   <= 4'hF;
                    r_valC <= 64'd0;
                    if (w_bad) r_stat <= 2'd2;
                end else if (r_cnt == 4'd1 && (r_len == 4'd2 || r_len == 4'd10)) begin
                    {r_rA, r_rB} <= mem_rdata;
                end else begin
                    // constant bytes arrive LSB first, so shifting in from the top lands them in place
                    r_valC <= {mem_rdata, r_valC[63:8]};
                end
                if (w_last) r_valP <= r_pc + {60'd0, w_len};
            end
            if (w_xfer) begin
                r_pc <= r_valP;
                if (r_icode == 4'h0) r_stat <= 2'd1;
            end
        end
    end

    assign out_valid = w_out;
    assign icode     = r_icode;
    assign ifun      = r_ifun;
    assign rA        = r_rA;
    assign rB        = r_rB;
    assign valC      = r_valC;
    assign valP      = r_valP;
    assign stat      = r_stat;
    assign srcA = !w_out ? 4'hF :
                  (r_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? r_rA :
                  (r_icode inside {4'h9, 4'hB}) ? RSP_ID : 4'hF;
    assign srcB = !w_out ? 4'hF :
                  (r_icode inside {4'h4, 4'h5, 4'h6}) ? r_rB :
                  (r_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP_ID : 4'hF;
    assign dstE = !w_out ? 4'hF :
                  (r_icode inside {4'h2, 4'h3, 4'h6}) ? r_rB :
                  (r_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? RSP_ID : 4'hF;
    assign dstM = !w_out ? 4'hF :
                  (r_icode inside {4'h5, 4'hB}) ? r_rA : 4'hF;
endmodule

// File: tb/tb_fetch_decode.sv
// tb_fetch_decode: directed vector table plus randomized program checked against a spec-level decode model.
module tb_fetch_decode;
    logic        clock = 1'b0, reset = 1'b1;
    logic        mem_req, mem_ack = 1'b1, pc_load = 1'b0, out_valid, out_ready = 1'b0;
    logic [63:0] mem_addr, pc_in = 64'd0, valC, valP;
    logic [7:0]  mem_rdata;
    logic [3:0]  icode, ifun, rA, rB, srcA, srcB, dstE, dstM;
    logic [1:0]  stat;
    logic [7:0]  mem [0:1023];
    bit          stall_en = 1'b0;
    int          n_tests = 0, n_fail = 0;

    typedef struct packed {
        logic [3:0]  icode, ifun, rA, rB, srcA, srcB, dstE, dstM;
        logic [63:0] valC, valP;
    } dec_t;
    typedef struct packed {
        logic [79:0] bytes;
        logic [3:0]  len;
        dec_t        e;
    } vec_t;

    always #5 clock = ~clock;
    assign mem_rdata = mem[mem_addr[9:0]];

    fetch_decode dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .valP(valP), .srcA(srcA), .srcB(srcB),
        .dstE(dstE), .dstM(dstM), .stat(stat)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic dec_t mkd(input logic [3:0] ic, fn, ra, rb, sa, sb, de, dm,
                                 input logic [63:0] vc, vp);
        dec_t d;
        d.icode = ic; d.ifun = fn; d.rA = ra; d.rB = rb;
        d.srcA = sa; d.srcB = sb; d.dstE = de; d.dstM = dm;
        d.valC = vc; d.valP = vp;
        return d;
    endfunction

    function automatic logic [7:0] rd(input logic [63:0] a);
        return mem[a[9:0]];
    endfunction

    // instruction-level reference: length table, field extraction, register-port rules
    function automatic dec_t model(input logic [63:0] pc);
        dec_t d;
        int len, off;
        logic [7:0] b0, b1;
        b0 = rd(pc);
        b1 = rd(pc + 64'd1);
        d.icode = b0[7:4];
        d.ifun  = b0[3:0];
        case (d.icode)
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            default:                len = 10;
        endcase
        d.rA = (len == 2 || len == 10) ? b1[7:4] : 4'hF;
        d.rB = (len == 2 || len == 10) ? b1[3:0] : 4'hF;
        off = len == 9 ? 1 : len == 10 ? 2 : 0;
        d.valC = 64'd0;
        if (off != 0)
            for (int i = 0; i < 8; i++) d.valC = d.valC | (64'(rd(pc + 64'(off + i))) << (8 * i));
        d.valP = pc + 64'(len);
        d.srcA = (d.icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? d.rA : (d.icode inside {4'h9, 4'hB}) ? 4'hE : 4'hF;
        d.srcB = (d.icode inside {4'h4, 4'h5, 4'h6}) ? d.rB : (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'hE : 4'hF;
        d.dstE = (d.icode inside {4'h2, 4'h3, 4'h6}) ? d.rB : (d.icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'hE : 4'hF;
        d.dstM = (d.icode inside {4'h5, 4'hB}) ? d.rA : 4'hF;
        return d;
    endfunction

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic put(input logic [63:0] a, input logic [79:0] b, input int n);
        for (int i = 0; i < n; i++) mem[10'(a + 64'(i))] = b[8*i +: 8];
    endtask

    task automatic redirect(input logic [63:0] a);
        pc_load = 1'b1;
        pc_in = a;
        tick;
        pc_load = 1'b0;
    endtask

    task automatic accept;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic get_instr(output int cyc);
        cyc = 1;
        while (!out_valid && cyc < 300) begin
            tick;
            cyc++;
        end
        chk("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic check_dec(input string t, input dec_t e);
        chk({t, ".icode"}, 64'(icode), 64'(e.icode));
        chk({t, ".ifun"},  64'(ifun),  64'(e.ifun));
        chk({t, ".rA"},    64'(rA),    64'(e.rA));
        chk({t, ".rB"},    64'(rB),    64'(e.rB));
        chk({t, ".srcA"},  64'(srcA),  64'(e.srcA));
        chk({t, ".srcB"},  64'(srcB),  64'(e.srcB));
        chk({t, ".dstE"},  64'(dstE),  64'(e.dstE));
        chk({t, ".dstM"},  64'(dstM),  64'(e.dstM));
        chk({t, ".valC"},  valC,       e.valC);
        chk({t, ".valP"},  valP,       e.valP);
    endtask

    // memory responder with optional random wait states, plus request/address hold check
    int          wait_n = 0;
    logic        p_req = 1'b0, p_ack = 1'b0, p_load = 1'b0;
    logic [63:0] p_addr = 64'd0;
    always @(negedge clock) begin
        #2;
        if (!reset && p_req && !p_ack && !p_load) begin
            chk("hold.mem_req", 64'(mem_req), 64'd1);
            chk("hold.mem_addr", mem_addr, p_addr);
        end
        if (!stall_en) mem_ack = 1'b1;
        else if (mem_req && wait_n > 0) begin
            mem_ack = 1'b0;
            wait_n--;
        end else begin
            mem_ack = mem_req;
            wait_n = $urandom_range(1, 3);
        end
        p_req  = mem_req;
        p_addr = mem_addr;
        p_ack  = mem_ack;
        p_load = pc_load;
    end

    vec_t vec [7];
    initial begin
        int cyc;
        logic [63:0] a, exp_pc;
        dec_t e;
        vec[0] = '{80'h1260,   4'd2, mkd(4'h6, 4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'hF, 64'h0, 64'h22)};
        vec[1] = '{80'h3FB0,   4'd2, mkd(4'hB, 4'h0, 4'h3, 4'hF, 4'hE, 4'hE, 4'hE, 4'h3, 64'h0, 64'h24)};
        vec[2] = '{80'h010080, 4'd9, mkd(4'h8, 4'h0, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hF, 64'h100, 64'h2D)};
        vec[3] = '{80'h104550, 4'd10, mkd(4'h5, 4'h0, 4'h4, 4'h5, 4'hF, 4'h5, 4'hF, 4'h4, 64'h10, 64'h37)};
        vec[4] = '{80'h90,     4'd1, mkd(4'h9, 4'h0, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 64'h0, 64'h38)};
        vec[5] = '{80'h3421,   4'd2, mkd(4'h2, 4'h1, 4'h3, 4'h4, 4'h3, 4'hF, 4'h4, 4'hF, 64'h0, 64'h3A)};
        vec[6] = '{80'h10,     4'd1, mkd(4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h3B)};
        for (int i = 0; i < 1024; i++) mem[i] = 8'h10;
        put(64'h0, 80'h0102030405060708F230, 10);

        tick;
        tick;
        chk("rst.mem_req", 64'(mem_req), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.stat", 64'(stat), 64'd0);
        check_dec("rst", mkd(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h0));

        reset = 1'b0;
        tick;
        get_instr(cyc);
        chk("t1.latency", 64'(cyc), 64'd11);
        check_dec("t1", mkd(4'h3, 4'h0, 4'hF, 4'h2, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0102030405060708, 64'd10));
        chk("t1.mem_req", 64'(mem_req), 64'd0);
        accept;

        a = 64'h20;
        foreach (vec[i]) begin
            put(a, vec[i].bytes, int'(vec[i].len));
            a = a + 64'(vec[i].len);
        end
        redirect(64'h20);
        foreach (vec[i]) begin
            get_instr(cyc);
            if (i > 0) chk($sformatf("v%0d.latency", i), 64'(cyc), 64'(vec[i].len) + 64'd1);
            check_dec($sformatf("v%0d", i), vec[i].e);
            chk($sformatf("v%0d.mem_req", i), 64'(mem_req), 64'd0);
            if (i == 2)
                repeat (5) begin
                    tick;
                    check_dec("hold", vec[i].e);
                    chk("hold.out_valid", 64'(out_valid), 64'd1);
                    chk("hold.no_req", 64'(mem_req), 64'd0);
                end
            accept;
        end

        put(64'h40, 80'h0102030405060708F230, 10);
        put(64'h100, 80'h1260, 2);
        redirect(64'h40);
        for (int k = 0; k < 50 && !(mem_req && mem_addr == 64'h43); k++) tick;
        chk("abort.reach", mem_addr, 64'h43);
        redirect(64'h100);
        chk("abort.gap", 64'(mem_req), 64'd0);
        tick;
        chk("abort.rereq", 64'(mem_req), 64'd1);
        chk("abort.addr", mem_addr, 64'h100);
        get_instr(cyc);
        check_dec("abort", mkd(4'h6, 4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'hF, 64'h0, 64'h102));
        out_ready = 1'b1;
        pc_load = 1'b1;
        pc_in = 64'h20;
        tick;
        pc_load = 1'b0;
        out_ready = 1'b0;
        chk("drop.out_valid", 64'(out_valid), 64'd0);
        get_instr(cyc);
        check_dec("drop", vec[0].e);
        accept;

        mem[1023] = 8'h60;
        mem[0] = 8'h12;
        mem[1] = 8'h10;
        redirect(64'hFFFF_FFFF_FFFF_FFFF);
        get_instr(cyc);
        check_dec("wrap", mkd(4'h6, 4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'hF, 64'h0, 64'h1));
        accept;

        mem[10'h200] = 8'hC0;
        redirect(64'h200);
        for (int k = 0; k < 20 && stat == 2'd0; k++) tick;
        chk("ins.stat", 64'(stat), 64'd2);
        chk("ins.out_valid", 64'(out_valid), 64'd0);
        repeat (3) begin
            tick;
            chk("ins.no_req", 64'(mem_req), 64'd0);
        end
        redirect(64'h20);
        tick;
        chk("ins.load_ignored", 64'(mem_req), 64'd0);
        chk("ins.stat_kept", 64'(stat), 64'd2);

        reset = 1'b1;
        tick;
        tick;
        chk("rst2.stat", 64'(stat), 64'd0);
        reset = 1'b0;
        tick;
        chk("rst2.req", 64'(mem_req), 64'd1);
        chk("rst2.addr", mem_addr, 64'h0);

        mem[10'h210] = 8'h00;
        redirect(64'h210);
        get_instr(cyc);
        check_dec("halt", mkd(4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0, 64'h211));
        chk("halt.stat_aok", 64'(stat), 64'd0);
        accept;
        chk("halt.stat", 64'(stat), 64'd1);
        chk("halt.out_valid", 64'(out_valid), 64'd0);
        repeat (3) begin
            tick;
            chk("halt.no_req", 64'(mem_req), 64'd0);
        end

        reset = 1'b1;
        tick;
        reset = 1'b0;
        a = 64'h300;
        for (int k = 0; k < 20; k++) begin
            logic [3:0] ic;
            logic [79:0] b;
            ic = 4'($urandom_range(1, 11));
            b = {$urandom, $urandom, $urandom};
            b[7:4] = ic;
            put(a, b, 10);
            a = model(a).valP;
        end
        stall_en = 1'b1;
        redirect(64'h300);
        exp_pc = 64'h300;
        for (int k = 0; k < 20; k++) begin
            e = model(exp_pc);
            get_instr(cyc);
            check_dec($sformatf("rnd%0d", k), e);
            repeat ($urandom_range(0, 3)) tick;
            accept;
            exp_pc = e.valP;
        end
        stall_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
